// File: rtl/pulse_seq_gen.sv
// ---------------------------------------------------------------------------
// pulse_seq_gen
//   Frame-based multi-channel pulse sequencer. A shared frame counter runs
//   0..period_s and wraps. Each channel raises its pulse while the count lies
//   in [delay+1, delay+width]. Continuous, burst and single-shot modes are
//   supported. All configuration goes through shadow registers. A
//   configuration loaded while running is held pending and takes effect at
//   the next frame wrap.
//
// Ports
//   m_clk       system clock, rising edge
//   m_rst       asynchronous active-high reset
//   en          run enable for continuous mode
//   trig        one-cycle start request for burst / single-shot
//   cfg_load    one-cycle request to capture all configuration inputs
//   mode        00 continuous, 01 burst, 10 single-shot, 11 off
//   period      terminal count; the frame lasts period+1 cycles
//   burst_len   number of frames per burst
//   ch_delay    packed per-channel delays, channel k at [k*DLY_W +: DLY_W]
//   ch_width    packed per-channel widths, channel k at [k*PW_W +: PW_W]
//   pulse_out   registered channel pulses
//   frame_sync  one-cycle marker per frame
//   busy        high while running
//   cfg_ack     one-cycle pulse after the shadow registers update
//
// State | meaning
//   IDLE  | counter parked at 0, waiting for en/trig (r_start arms the start)
//   RUN   | frame counter active, stop is decided only at frame wrap
// ---------------------------------------------------------------------------
module pulse_seq_gen #(
    parameter int CNT_W = 32,
    parameter int N_CH  = 2,
    parameter int DLY_W = 16,
    parameter int PW_W  = 8,
    parameter int BL_W  = 8
) (
    input  logic                  m_clk,
    input  logic                  m_rst,
    input  logic                  en,
    input  logic                  trig,
    input  logic                  cfg_load,
    input  logic [1:0]            mode,
    input  logic [CNT_W-1:0]      period,
    input  logic [BL_W-1:0]       burst_len,
    input  logic [N_CH*DLY_W-1:0] ch_delay,
    input  logic [N_CH*PW_W-1:0]  ch_width,
    output logic [N_CH-1:0]       pulse_out,
    output logic                  frame_sync,
    output logic                  busy,
    output logic                  cfg_ack
);
    localparam int CW1 = CNT_W + 1;
    localparam int BW1 = BL_W + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [1:0] M_CONT   = 2'b00;
    localparam logic [1:0] M_BURST  = 2'b01;
    localparam logic [1:0] M_SINGLE = 2'b10;
    localparam logic [1:0] M_OFF    = 2'b11;

    logic [0:0]            r_state;
    logic                  r_start;
    logic [CNT_W-1:0]      r_count;
    logic [BL_W-1:0]       r_frames;

    logic [1:0]            r_mode_s;
    logic [CNT_W-1:0]      r_period_s;
    logic [BL_W-1:0]       r_bl_s;
    logic [N_CH*DLY_W-1:0] r_dly_s;
    logic [N_CH*PW_W-1:0]  r_wid_s;

    logic                  r_pend;
    logic [1:0]            r_mode_p;
    logic [CNT_W-1:0]      r_period_p;
    logic [BL_W-1:0]       r_bl_p;
    logic [N_CH*DLY_W-1:0] r_dly_p;
    logic [N_CH*PW_W-1:0]  r_wid_p;

    logic [N_CH-1:0]       r_pulse;
    logic                  r_fsync;
    logic                  r_cfg_ack;

    logic [CNT_W-1:0]      w_per_eff;
    logic                  w_wrap;
    logic                  w_apply;
    logic [1:0]            w_src_mode;
    logic [CNT_W-1:0]      w_src_period;
    logic [BL_W-1:0]       w_src_bl;
    logic [N_CH*DLY_W-1:0] w_src_dly;
    logic [N_CH*PW_W-1:0]  w_src_wid;
    logic [1:0]            w_nxt_mode;
    logic [BL_W-1:0]       w_nxt_bl;
    logic [BL_W-1:0]       w_bl_eff;
    logic                  w_last_frame;
    logic                  w_start_req;
    logic [CW1-1:0]        w_cnt_x;
    logic [N_CH-1:0]       w_hit;

    assign w_per_eff = (r_period_s == '0) ? CNT_W'(1) : r_period_s;
    assign w_wrap    = (r_state == S_RUN) && (r_count == w_per_eff);

    // A load on the wrap cycle itself wins over an older pending request.
    assign w_src_mode   = cfg_load ? mode      : r_mode_p;
    assign w_src_period = cfg_load ? period    : r_period_p;
    assign w_src_bl     = cfg_load ? burst_len : r_bl_p;
    assign w_src_dly    = cfg_load ? ch_delay  : r_dly_p;
    assign w_src_wid    = cfg_load ? ch_width  : r_wid_p;

    assign w_apply = ((r_state == S_IDLE) && cfg_load) || (w_wrap && (cfg_load || r_pend));

    // Start and stop decisions look at the configuration that is in force
    // after this edge, so a same-cycle load and trigger starts with the new setup.
    assign w_nxt_mode = w_apply ? w_src_mode : r_mode_s;
    assign w_nxt_bl   = w_apply ? w_src_bl   : r_bl_s;
    assign w_bl_eff   = (w_nxt_bl == '0) ? BL_W'(1) : w_nxt_bl;

    assign w_start_req = (r_state == S_IDLE) && !r_start &&
                         (((w_nxt_mode == M_CONT) && en) ||
                          (((w_nxt_mode == M_BURST) || (w_nxt_mode == M_SINGLE)) && trig));

    always_comb begin
        w_last_frame = 1'b1;
        case (w_nxt_mode)
            M_CONT:   w_last_frame = !en;
            M_BURST:  w_last_frame = ({1'b0, r_frames} + BW1'(1)) >= {1'b0, w_bl_eff};
            M_SINGLE: w_last_frame = 1'b1;
            M_OFF:    w_last_frame = 1'b1;
            default:  w_last_frame = 1'b1;
        endcase
    end

    // One extra bit keeps delay+width from wrapping around.
    assign w_cnt_x = {1'b0, r_count};

    always_comb begin
        w_hit = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_hit[k] = (r_wid_s[k*PW_W +: PW_W] != '0) &&
                       (w_cnt_x >= CW1'(r_dly_s[k*DLY_W +: DLY_W]) + CW1'(1)) &&
                       (w_cnt_x <= CW1'(r_dly_s[k*DLY_W +: DLY_W]) + CW1'(r_wid_s[k*PW_W +: PW_W]));
        end
    end

    always_ff @(posedge m_clk or posedge m_rst) begin
        if (m_rst) begin
            r_state    <= S_IDLE;
            r_start    <= 1'b0;
            r_count    <= '0;
            r_frames   <= '0;
            r_mode_s   <= M_OFF;
            r_period_s <= '0;
            r_bl_s     <= '0;
            r_dly_s    <= '0;
            r_wid_s    <= '0;
            r_pend     <= 1'b0;
            r_mode_p   <= '0;
            r_period_p <= '0;
            r_bl_p     <= '0;
            r_dly_p    <= '0;
            r_wid_p    <= '0;
            r_pulse    <= '0;
            r_fsync    <= 1'b0;
            r_cfg_ack  <= 1'b0;
        end else begin
            r_cfg_ack <= w_apply;
            r_fsync   <= (r_state == S_RUN) && (r_count == '0);
            r_pulse   <= (r_state == S_RUN) ? w_hit : '0;

            if (w_apply) begin
                r_mode_s   <= w_src_mode;
                r_period_s <= w_src_period;
                r_bl_s     <= w_src_bl;
                r_dly_s    <= w_src_dly;
                r_wid_s    <= w_src_wid;
            end

            if (r_state == S_RUN) begin
                if (w_wrap) begin
                    r_pend <= 1'b0;
                end else if (cfg_load) begin
                    r_pend     <= 1'b1;
                    r_mode_p   <= mode;
                    r_period_p <= period;
                    r_bl_p     <= burst_len;
                    r_dly_p    <= ch_delay;
                    r_wid_p    <= ch_width;
                end
            end

            case (r_state)
                S_IDLE: begin
                    r_count <= '0;
                    if (r_start) begin
                        r_start  <= 1'b0;
                        r_state  <= S_RUN;
                        r_frames <= '0;
                    end else if (w_start_req) begin
                        r_start <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_wrap) begin
                        r_count <= '0;
                        if (w_last_frame) begin
                            r_state <= S_IDLE;
                        end else if (r_frames != '1) begin
                            r_frames <= r_frames + 1'b1;
                        end
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_start <= 1'b0;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign pulse_out  = r_pulse;
    assign frame_sync = r_fsync;
    assign busy       = (r_state == S_RUN);
    assign cfg_ack    = r_cfg_ack;

endmodule

// File: tb/tb_pulse_seq_gen.sv
module tb_pulse_seq_gen;
    localparam int CNT_W = 32;
    localparam int N_CH  = 2;
    localparam int DLY_W = 16;
    localparam int PW_W  = 8;
    localparam int BL_W  = 8;

    logic                  m_clk = 1'b0;
    logic                  m_rst = 1'b1;
    logic                  en = 1'b0;
    logic                  trig = 1'b0;
    logic                  cfg_load = 1'b0;
    logic [1:0]            mode = 2'b11;
    logic [CNT_W-1:0]      period = '0;
    logic [BL_W-1:0]       burst_len = '0;
    logic [N_CH*DLY_W-1:0] ch_delay = '0;
    logic [N_CH*PW_W-1:0]  ch_width = '0;
    logic [N_CH-1:0]       pulse_out;
    logic                  frame_sync;
    logic                  busy;
    logic                  cfg_ack;

    always #5 m_clk = ~m_clk;

    pulse_seq_gen #(
        .CNT_W(CNT_W), .N_CH(N_CH), .DLY_W(DLY_W), .PW_W(PW_W), .BL_W(BL_W)
    ) dut (
        .m_clk(m_clk), .m_rst(m_rst), .en(en), .trig(trig), .cfg_load(cfg_load),
        .mode(mode), .period(period), .burst_len(burst_len),
        .ch_delay(ch_delay), .ch_width(ch_width),
        .pulse_out(pulse_out), .frame_sync(frame_sync), .busy(busy), .cfg_ack(cfg_ack)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int p, bl, md, d0, w0, d1, w1;
        int frames, spacing, first0, tot0, first1, tot1;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic set_cfg(input int p, input int bl, input int md,
                           input int d0, input int w0, input int d1, input int w1);
        mode      = 2'(md);
        period    = 32'(p);
        burst_len = 8'(bl);
        ch_delay  = {16'(d1), 16'(d0)};
        ch_width  = {8'(w1), 8'(w0)};
    endtask

    task automatic load_cfg();
        @(negedge m_clk); cfg_load = 1'b1;
        @(negedge m_clk); cfg_load = 1'b0;
        chk("cfg_ack_idle", 32'(cfg_ack), 1);
        @(negedge m_clk);
        chk("cfg_ack_clear", 32'(cfg_ack), 0);
    endtask

    task automatic start_trig();
        @(negedge m_clk); trig = 1'b1;
        @(negedge m_clk); trig = 1'b0;
        chk("arm_busy", 32'(busy), 0);
    endtask

    // Reference: c counts cycles from the first RUN cycle. The run lasts F
    // frames of L cycles; registered outputs trail the counter by one cycle.
    function automatic logic [3:0] exp_out(input int c, input int L, input int F,
                                           input int d0, input int w0, input int d1, input int w1);
        int t, o;
        logic b, fs, p0, p1, in_run;
        b      = (c >= 0) && (c < F * L);
        t      = c - 1;
        in_run = (t >= 0) && (t < F * L);
        o      = (t >= 0) ? (t % L) : 0;
        fs     = in_run && (o == 0);
        p0     = in_run && (w0 > 0) && (o >= d0 + 1) && (o <= d0 + w0);
        p1     = in_run && (w1 > 0) && (o >= d1 + 1) && (o <= d1 + w1);
        return {b, fs, p1, p0};
    endfunction

    task automatic run_model(input string name, input int L, input int F,
                             input int d0, input int w0, input int d1, input int w1,
                             input int trig_at, input int en_drop_at);
        for (int c = 0; c < F * L + 3; c++) begin
            @(negedge m_clk);
            chk($sformatf("%s c=%0d {busy,fs,pulse}", name, c),
                {28'd0, busy, frame_sync, pulse_out},
                {28'd0, exp_out(c, L, F, d0, w0, d1, w1)});
            trig = (c == trig_at);
            if (c == en_drop_at) en = 1'b0;
        end
        trig = 1'b0;
    endtask

    task automatic measure(output int frames, output int spacing, output int first0,
                           output int tot0, output int first1, output int tot1);
        int fs_t, prev, tail;
        bit seen_busy, consistent;
        frames = 0; spacing = 0; first0 = -1; tot0 = 0; first1 = -1; tot1 = 0;
        fs_t = 0; prev = 0; tail = 0; seen_busy = 0; consistent = 1;
        for (int cyc = 0; cyc < 300 && tail < 3; cyc++) begin
            @(negedge m_clk);
            if (busy) seen_busy = 1;
            if (frame_sync) begin
                if (frames == 0) fs_t = cyc;
                else if (frames == 1) spacing = cyc - prev;
                else if (cyc - prev != spacing) consistent = 0;
                prev = cyc;
                frames++;
            end
            if (pulse_out[0]) begin tot0++; if (first0 < 0) first0 = cyc - fs_t; end
            if (pulse_out[1]) begin tot1++; if (first1 < 0) first1 = cyc - fs_t; end
            if (seen_busy && !busy) tail++;
        end
        if (!consistent) spacing = -1;
        chk("measure_run_ended", 32'(tail), 3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fr, sp, f0, t0, f1, t1;
        int fs_q[$];
        int ack_q[$];
        int exp_fs[4];
        bit saw_busy;

        tbl[0] = '{4, 3, 1, 0, 2, 1, 1,            3, 5,  1, 6,  2, 3};
        tbl[1] = '{5, 0, 2, 3, 10, 0, 0,           1, 0,  4, 2, -1, 0};
        tbl[2] = '{3, 0, 1, 0, 1, 2, 1,            1, 0,  1, 1,  3, 1};
        tbl[3] = '{0, 0, 2, 0, 1, 0, 5,            1, 0,  1, 1,  1, 1};
        tbl[4] = '{3, 0, 2, 3, 2, 2, 4,            1, 0, -1, 0,  3, 1};
        tbl[5] = '{7, 2, 1, 5, 2, 6, 1,            2, 8,  6, 4,  7, 2};
        tbl[6] = '{9, 1, 1, 65535, 255, 8, 255,    1, 0, -1, 0,  9, 1};
        tbl[7] = '{2, 4, 1, 1, 1, 0, 3,            4, 3,  2, 4,  1, 8};
        exp_fs = '{1, 11, 31, 51};

        // Reset values
        repeat (3) @(negedge m_clk);
        chk("rst pulse_out", 32'(pulse_out), 0);
        chk("rst frame_sync", 32'(frame_sync), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst cfg_ack", 32'(cfg_ack), 0);
        m_rst = 1'b0;

        // Off mode after reset: en and trig must not start anything
        mode = 2'b00; en = 1'b1; saw_busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge m_clk);
            trig = (i % 4 == 0);
            if (busy) saw_busy = 1;
        end
        trig = 1'b0; en = 1'b0;
        chk("off after reset busy", 32'(saw_busy), 0);

        // Table-driven burst / single-shot scenarios
        for (int i = 0; i < 8; i++) begin
            set_cfg(tbl[i].p, tbl[i].bl, tbl[i].md, tbl[i].d0, tbl[i].w0, tbl[i].d1, tbl[i].w1);
            load_cfg();
            start_trig();
            measure(fr, sp, f0, t0, f1, t1);
            chk($sformatf("tbl%0d frames", i), fr, tbl[i].frames);
            chk($sformatf("tbl%0d spacing", i), sp, tbl[i].spacing);
            chk($sformatf("tbl%0d ch0 first", i), f0, tbl[i].first0);
            chk($sformatf("tbl%0d ch0 total", i), t0, tbl[i].tot0);
            chk($sformatf("tbl%0d ch1 first", i), f1, tbl[i].first1);
            chk($sformatf("tbl%0d ch1 total", i), t1, tbl[i].tot1);
        end

        // Continuous: 1000 frames, en dropped at count=3 of the last frame
        set_cfg(9, 0, 0, 0, 2, 3, 3);
        load_cfg();
        @(negedge m_clk); en = 1'b1;
        @(negedge m_clk);
        chk("cont arm busy", 32'(busy), 0);
        run_model("cont", 10, 1000, 0, 2, 3, 3, -1, 999 * 10 + 3);

        // Burst with an ignored second trigger in RUN
        set_cfg(4, 3, 1, 0, 1, 2, 2);
        load_cfg();
        start_trig();
        run_model("burst", 5, 3, 0, 1, 2, 2, 7, -1);

        // Reconfigure while running; the second load overwrites the first
        set_cfg(9, 0, 0, 0, 2, 3, 3);
        load_cfg();
        @(negedge m_clk); en = 1'b1;
        @(negedge m_clk);
        for (int c = 0; c < 60; c++) begin
            @(negedge m_clk);
            if (frame_sync) fs_q.push_back(c);
            if (cfg_ack) ack_q.push_back(c);
            if (c == 4) begin period = 32'd14; cfg_load = 1'b1; end
            if (c == 5) cfg_load = 1'b0;
            if (c == 6) begin period = 32'd19; cfg_load = 1'b1; end
            if (c == 7) cfg_load = 1'b0;
        end
        chk("recfg fs count", 32'(fs_q.size()), 4);
        for (int i = 0; i < 4; i++)
            if (i < fs_q.size()) chk($sformatf("recfg fs%0d cycle", i), fs_q[i], exp_fs[i]);
        chk("recfg ack count", 32'(ack_q.size()), 1);
        if (ack_q.size() > 0) chk("recfg ack cycle", ack_q[0], 10);
        en = 1'b0;
        for (int i = 0; i < 50 && busy; i++) @(negedge m_clk);
        chk("recfg stopped", 32'(busy), 0);
        repeat (2) @(negedge m_clk);

        // Randomized burst / single-shot runs
        for (int r = 0; r < 30; r++) begin
            int p, bl, md, d0, w0, d1, w1, L, F;
            p  = int'($urandom_range(0, 12));
            bl = int'($urandom_range(0, 4));
            md = int'($urandom_range(1, 2));
            d0 = int'($urandom_range(0, 14));
            w0 = int'($urandom_range(0, 6));
            d1 = int'($urandom_range(0, 14));
            w1 = int'($urandom_range(0, 6));
            L  = ((p == 0) ? 1 : p) + 1;
            F  = (md == 2) ? 1 : ((bl == 0) ? 1 : bl);
            set_cfg(p, bl, md, d0, w0, d1, w1);
            load_cfg();
            start_trig();
            run_model($sformatf("rnd%0d", r), L, F, d0, w0, d1, w1, -1, -1);
        end

        // Asynchronous reset mid-frame with a pulse high
        set_cfg(9, 0, 0, 3, 5, 0, 0);
        load_cfg();
        @(negedge m_clk); en = 1'b1;
        @(negedge m_clk);
        for (int c = 0; c <= 5; c++) @(negedge m_clk);
        chk("pre-reset pulse", 32'(pulse_out), 1);
        chk("pre-reset busy", 32'(busy), 1);
        #1 m_rst = 1'b1;
        #1;
        chk("async rst pulse_out", 32'(pulse_out), 0);
        chk("async rst frame_sync", 32'(frame_sync), 0);
        chk("async rst busy", 32'(busy), 0);
        chk("async rst cfg_ack", 32'(cfg_ack), 0);
        @(negedge m_clk); m_rst = 1'b0;
        saw_busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge m_clk);
            trig = (i % 5 == 1);
            if (busy) saw_busy = 1;
        end
        trig = 1'b0; en = 1'b0;
        chk("idle after reset release", 32'(saw_busy), 0);

        // cfg_load and trig in the same IDLE cycle: start uses the new config
        set_cfg(3, 0, 2, 0, 1, 1, 2);
        @(negedge m_clk); cfg_load = 1'b1; trig = 1'b1;
        @(negedge m_clk); cfg_load = 1'b0; trig = 1'b0;
        chk("cfg+trig ack", 32'(cfg_ack), 1);
        chk("cfg+trig arm busy", 32'(busy), 0);
        run_model("cfg+trig", 4, 1, 0, 1, 1, 2, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
